regfile_mp: RTL

- Parametrised multi-port integer register file with an integrated scoreboard; successor to the single-write, two-read register file.
- Serves the pipelined core. Decode issues reads and allocates destination registers (marks them busy). Writeback ports retire results and clear busy bits.
- Optional same-cycle write-to-read bypass removes one forwarding stage from the datapath.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/rf_scoreboard.sv | 69 ++++++
 rtl/regfile_mp.sv | 126 ++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared constants and types for the multi-port register file and its
// scoreboard. The typedefs are sized for the default configuration.
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;
    localparam int AW_DEFAULT    = $clog2(NREGS_DEFAULT);

    typedef logic [AW_DEFAULT-1:0]   reg_addr_t;
    typedef logic [XLEN_DEFAULT-1:0] xword_t;

endpackage

// File: rtl/rf_scoreboard.sv
// -----------------------------------------------------------------------------
// rf_scoreboard
// Tracks which architectural registers have an outstanding producer.
// A register becomes busy when decode allocates it. It becomes idle when a
// writeback port retires it. Register 0 is never busy.
//
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   alloc_en    - allocate alloc_addr this cycle
//   alloc_addr  - register being allocated
//   retire      - one bit per register: an enabled write targets it this cycle
//   busy_q      - registered busy bits
//   busy_count  - registered population count of busy_q
// -----------------------------------------------------------------------------
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter  int NREGS = NREGS_DEFAULT,
    localparam int AW    = $clog2(NREGS),
    localparam int CW    = $clog2(NREGS) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alloc_en,
    input  logic [AW-1:0]    alloc_addr,
    input  logic [NREGS-1:0] retire,
    output logic [NREGS-1:0] busy_q,
    output logic [CW-1:0]    busy_count
);

    logic [NREGS-1:0] busy_d;
    logic [CW-1:0]    count_d;

    // Allocation takes priority over a retiring write. In that case the write
    // belongs to the previous producer, and the new producer is still in flight.
    // Register 0 is forced idle after the loop.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < NREGS; i++) begin
            if (alloc_en && (alloc_addr == AW'(i))) begin
                busy_d[i] = 1'b1;
            end else if (retire[i]) begin
                busy_d[i] = 1'b0;
            end
        end
        busy_d[0] = 1'b0;
    end

    // The count is taken from the next-state vector. As a result, busy_count
    // and busy_q always describe the same post-edge state.
    always_comb begin
        count_d = '0;
        for (int i = 0; i < NREGS; i++) begin
            count_d = count_d + CW'(busy_d[i]);
        end
    end

    // Busy state register. Reset drops all outstanding allocations.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q     <= '0;
            busy_count <= '0;
        end else begin
            busy_q     <= busy_d;
            busy_count <= count_d;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
// Multi-port integer register file with an integrated busy scoreboard.
// Reads are combinational. With BYPASS=1, same-cycle write data is forwarded
// to the read ports. Register 0 reads as zero and is never busy.
//
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   rd_addr     - NREAD read addresses
//   rd_data     - NREAD read data words
//   rd_busy     - NREAD flags: the addressed register has an outstanding producer
//   wr_en       - NWRITE write strobes
//   wr_addr     - NWRITE write addresses
//   wr_data     - NWRITE write data words
//   alloc_en    - mark alloc_addr busy
//   alloc_addr  - register to allocate
//   busy_count  - registered number of busy registers
//   wr_conflict - registered flag: two or more enabled ports hit the same
//                 nonzero address on the previous edge
// -----------------------------------------------------------------------------
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int XLEN   = XLEN_DEFAULT,
    parameter  int NREGS  = NREGS_DEFAULT,
    parameter  int NREAD  = 2,
    parameter  int NWRITE = 2,
    parameter  int BYPASS = 1,
    localparam int AW     = $clog2(NREGS),
    localparam int CW     = $clog2(NREGS) + 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NREAD-1:0][AW-1:0]     rd_addr,
    output logic [NREAD-1:0][XLEN-1:0]   rd_data,
    output logic [NREAD-1:0]             rd_busy,
    input  logic [NWRITE-1:0]            wr_en,
    input  logic [NWRITE-1:0][AW-1:0]    wr_addr,
    input  logic [NWRITE-1:0][XLEN-1:0]  wr_data,
    input  logic                         alloc_en,
    input  logic [AW-1:0]                alloc_addr,
    output logic [CW-1:0]                busy_count,
    output logic                         wr_conflict
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] wr_hit;
    logic [XLEN-1:0]  wr_val [NREGS];
    logic [NREGS-1:0] busy_q;
    logic             conflict_d;

    // Per-register write decode. Ports are scanned in ascending order, so the
    // highest-index enabled port targeting a register supplies its value.
    // Writes to register 0 never produce a hit.
    always_comb begin
        wr_hit = '0;
        for (int i = 0; i < NREGS; i++) begin
            wr_val[i] = '0;
        end
        for (int p = 0; p < NWRITE; p++) begin
            if (wr_en[p] && (wr_addr[p] != '0)) begin
                wr_hit[wr_addr[p]] = 1'b1;
                wr_val[wr_addr[p]] = wr_data[p];
            end
        end
    end

    // Report a conflict when any pair of enabled ports targets the same
    // nonzero address.
    always_comb begin
        conflict_d = 1'b0;
        for (int p = 0; p < NWRITE; p++) begin
            for (int q = p + 1; q < NWRITE; q++) begin
                if (wr_en[p] && wr_en[q] && (wr_addr[p] == wr_addr[q]) &&
                    (wr_addr[p] != '0)) begin
                    conflict_d = 1'b1;
                end
            end
        end
    end

    // Storage array and conflict flag. Register 0 is held at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            wr_conflict <= 1'b0;
        end else begin
            regs_q[0] <= '0;
            for (int i = 1; i < NREGS; i++) begin
                if (wr_hit[i]) begin
                    regs_q[i] <= wr_val[i];
                end
            end
            wr_conflict <= conflict_d;
        end
    end

    // Read muxing. With bypass enabled, a same-cycle write supplies both the
    // data and the retirement of the busy bit. Register 0 needs no special
    // case: its storage is zero, it is never busy, and it never hits.
    always_comb begin
        for (int r = 0; r < NREAD; r++) begin
            rd_data[r] = regs_q[rd_addr[r]];
            rd_busy[r] = busy_q[rd_addr[r]];
            if ((BYPASS != 0) && wr_hit[rd_addr[r]]) begin
                rd_data[r] = wr_val[rd_addr[r]];
                rd_busy[r] = 1'b0;
            end
        end
    end

    rf_scoreboard #(
        .NREGS (NREGS)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .retire     (wr_hit),
        .busy_q     (busy_q),
        .busy_count (busy_count)
    );

endmodule
